// File: rtl/xnor_share_cmp.sv
// Bit-serial word comparator that time-shares one external XNOR cell between
// two requesters under round-robin arbitration; returns the XNOR word and an equality flag.
module xnor_share_cmp #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             xa,
    output logic             xb,
    input  logic             xf,
    output logic             busy,
    output logic             res_valid,
    output logic             res_id,
    output logic             res_eq,
    output logic [WIDTH-1:0] res_xnor
);
    // Handshake: a pair moves on the rising edge where reqN_valid && reqN_ready;
    // ready is combinational, high only in IDLE for the granted requester, and a
    // requester holds valid/operands stable until it sees ready.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // state is kept as a plainly named register so checkers can bind to it
    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             id_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc;
    logic             eq_acc;

    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             accept_id;
    logic             last_bit;
    logic [WIDTH-1:0] acc_shifted;

    always_comb begin
        grant0 = req0_valid && (!req1_valid || last);
        grant1 = req1_valid && (!req0_valid || !last);
    end

    assign req0_ready = (state == IDLE) && !rst && grant0;
    assign req1_ready = (state == IDLE) && !rst && grant1;
    assign accept     = req0_ready || req1_ready;
    assign accept_id  = req1_ready;
    assign last_bit   = (cnt == CW'(WIDTH - 1));

    // Operands shift right so bit cnt always sits at position 0; the XNOR bit
    // enters acc from the top, so after WIDTH shifts bit k lands at position k.
    assign acc_shifted = (acc >> 1) | (WIDTH'(xf) << (WIDTH - 1));

    assign xa        = (state == SHIFT) && a_reg[0];
    assign xb        = (state == SHIFT) && b_reg[0];
    assign busy      = (state != IDLE);
    assign res_valid = (state == DONE);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            last     <= 1'b1;
            id_reg   <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            eq_acc   <= 1'b0;
            res_id   <= 1'b0;
            res_eq   <= 1'b0;
            res_xnor <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg  <= accept_id ? req1_a : req0_a;
                        b_reg  <= accept_id ? req1_b : req0_b;
                        id_reg <= accept_id;
                        last   <= accept_id;
                        acc    <= '0;
                        eq_acc <= 1'b1;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    a_reg  <= a_reg >> 1;
                    b_reg  <= b_reg >> 1;
                    acc    <= acc_shifted;
                    eq_acc <= eq_acc & xf;
                    // Results load on the final SHIFT edge so they are already
                    // visible during the DONE cycle, alongside res_valid.
                    if (last_bit) begin
                        res_xnor <= acc_shifted;
                        res_eq   <= eq_acc & xf;
                        res_id   <= id_reg;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xnor_share_cmp.sv
// Self-checking bench for xnor_share_cmp: WIDTH=8 and WIDTH=1 instances, directed
// scenarios plus randomized pairs against a word-level XNOR/equality model.
module tb_xnor_share_cmp;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;

    logic         v0, v1, r0, r1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         xa, xb, xf, busy, rv, rid, req;
    logic [W-1:0] rx;

    logic       s_v0, s_v1, s_r0, s_r1;
    logic [0:0] s_a0, s_b0, s_a1, s_b1;
    logic       s_xa, s_xb, s_xf, s_busy, s_rv, s_rid, s_req;
    logic [0:0] s_rx;

    int total = 0;
    int bad   = 0;

    // Behavioural stand-in for the shared CMOS XNOR cell
    assign xf   = ~(xa ^ xb);
    assign s_xf = ~(s_xa ^ s_xb);

    xnor_share_cmp #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_a(a0), .req0_b(b0), .req0_ready(r0),
        .req1_valid(v1), .req1_a(a1), .req1_b(b1), .req1_ready(r1),
        .xa(xa), .xb(xb), .xf(xf), .busy(busy),
        .res_valid(rv), .res_id(rid), .res_eq(req), .res_xnor(rx)
    );

    xnor_share_cmp #(.WIDTH(1)) dut_w1 (
        .clk(clk), .rst(rst),
        .req0_valid(s_v0), .req0_a(s_a0), .req0_b(s_b0), .req0_ready(s_r0),
        .req1_valid(s_v1), .req1_a(s_a1), .req1_b(s_b1), .req1_ready(s_r1),
        .xa(s_xa), .xb(s_xb), .xf(s_xf), .busy(s_busy),
        .res_valid(s_rv), .res_id(s_rid), .res_eq(s_req), .res_xnor(s_rx)
    );

    always #5 clk = ~clk;

    // Per-cycle observations of one transaction, cycle 0 = acceptance cycle
    logic         t_r0[0:15], t_r1[0:15], t_xa[0:15], t_xb[0:15];
    logic         t_busy[0:15], t_rv[0:15], t_rid[0:15], t_req[0:15];
    logic [W-1:0] t_rx[0:15];

    task tick;
        @(posedge clk);
        #1;
    endtask

    task automatic record(input int k);
        t_r0[k] = r0;  t_r1[k] = r1;  t_xa[k] = xa;  t_xb[k] = xb;
        t_busy[k] = busy;  t_rv[k] = rv;  t_rid[k] = rid;  t_req[k] = req;
        t_rx[k] = rx;
    endtask

    // Presents one pair in the current cycle, drops valid after the first edge
    task automatic run_pair(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                            input int ncyc);
        if (id) begin v1 = 1'b1; a1 = a; b1 = b; end
        else    begin v0 = 1'b1; a0 = a; b0 = b; end
        #1 record(0);
        for (int k = 1; k < ncyc; k++) begin
            tick;
            if (k == 1) begin v0 = 1'b0; v1 = 1'b0; end
            #1 record(k);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; v0 = 1'b1; v1 = 1'b1;
        tick; tick; #1;
        total++; if ({r0, r1} !== 2'b00) begin bad++;
            $display("FAIL reset_ready: got %b%b exp 00", r0, r1); end
        tick; rst = 1'b0; v0 = 1'b0; v1 = 1'b0; #1;
        total++; if ({r0, r1, xa, xb, busy, rv, rid, req, rx} !== '0) begin bad++;
            $display("FAIL reset_outputs: rdy=%b%b x=%b%b busy=%b rv=%b id=%b eq=%b rx=%h exp all 0",
                     r0, r1, xa, xb, busy, rv, rid, req, rx); end
        total++; if ({s_r0, s_r1, s_xa, s_xb, s_busy, s_rv, s_rid, s_req, s_rx} !== '0) begin bad++;
            $display("FAIL reset_outputs_w1: got nonzero, exp all 0"); end
    endtask

    task automatic test_match;
        logic [W-1:0] a, b;
        a = 8'hA5; b = 8'hA5;
        tick; run_pair(1'b0, a, b, 11);
        total++; if ({t_r0[0], t_r1[0]} !== 2'b10) begin bad++;
            $display("FAIL match_ready: got %b%b exp 10", t_r0[0], t_r1[0]); end
        total++; if ({t_rv[8], t_rv[9], t_rv[10]} !== 3'b010) begin bad++;
            $display("FAIL match_res_valid c8..10: got %b%b%b exp 010", t_rv[8], t_rv[9], t_rv[10]); end
        total++; if (t_rid[9] !== 1'b0) begin bad++;
            $display("FAIL match_res_id: got %b exp 0", t_rid[9]); end
        total++; if (t_req[9] !== (a == b)) begin bad++;
            $display("FAIL match_res_eq: got %b exp %b", t_req[9], (a == b)); end
        total++; if (t_rx[9] !== ~(a ^ b)) begin bad++;
            $display("FAIL match_res_xnor: got %h exp %h", t_rx[9], ~(a ^ b)); end
        total++; if (t_rx[10] !== ~(a ^ b)) begin bad++;
            $display("FAIL match_res_hold: got %h exp %h", t_rx[10], ~(a ^ b)); end
    endtask

    task automatic test_full_mismatch;
        logic [W-1:0] a, b;
        logic [1:0]   exp_x;
        a = 8'hA5; b = 8'h5A;
        tick; run_pair(1'b1, a, b, 11);
        total++; if ({t_r0[0], t_r1[0]} !== 2'b01) begin bad++;
            $display("FAIL mism_ready: got %b%b exp 01", t_r0[0], t_r1[0]); end
        total++; if ({t_rv[9], t_rid[9], t_req[9]} !== {1'b1, 1'b1, (a == b)}) begin bad++;
            $display("FAIL mism_res: got rv=%b id=%b eq=%b exp rv=1 id=1 eq=%b",
                     t_rv[9], t_rid[9], t_req[9], (a == b)); end
        total++; if (t_rx[9] !== ~(a ^ b)) begin bad++;
            $display("FAIL mism_res_xnor: got %h exp %h", t_rx[9], ~(a ^ b)); end
        for (int k = 0; k <= 10; k++) begin
            exp_x = (k >= 1 && k <= W) ? {a[k-1], b[k-1]} : 2'b00;
            total++; if ({t_xa[k], t_xb[k]} !== exp_x) begin bad++;
                $display("FAIL mism_xab cycle %0d: got %b%b exp %b", k, t_xa[k], t_xb[k], exp_x); end
        end
    endtask

    task automatic test_single_bit;
        logic [W-1:0] a, b;
        logic         exp_busy;
        a = 8'hF0; b = 8'hF1;
        tick; run_pair(1'b0, a, b, 11);
        total++; if ({t_req[9], t_rx[9]} !== {(a == b), ~(a ^ b)}) begin bad++;
            $display("FAIL single_res: got eq=%b rx=%h exp eq=%b rx=%h",
                     t_req[9], t_rx[9], (a == b), ~(a ^ b)); end
        for (int k = 0; k <= 10; k++) begin
            exp_busy = (k >= 1 && k <= W + 1);
            total++; if (t_busy[k] !== exp_busy) begin bad++;
                $display("FAIL single_busy cycle %0d: got %b exp %b", k, t_busy[k], exp_busy); end
        end
        total++; if ({t_xa[0], t_xb[0], t_xa[9], t_xb[9]} !== 4'b0000) begin bad++;
            $display("FAIL single_xab_idle: got %b%b/%b%b exp 00/00", t_xa[0], t_xb[0], t_xa[9], t_xb[9]); end
    endtask

    task automatic test_arbitration;
        logic [W+1:0] exp_q[$];
        logic [W+1:0] got, exp;
        bit           m_last, exp_id, exp_r0, exp_r1, exp_rv;
        int           n_res;
        tick; rst = 1'b1;
        tick; rst = 1'b0; m_last = 1'b1; n_res = 0;
        v0 = 1'b1; v1 = 1'b1;
        a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = a1;
        for (int k = 0; k <= 30; k++) begin
            if (k > 0) tick;
            if (k == 1)  begin a0 = W'($urandom); b0 = a0 ^ W'(1 << $urandom_range(0, W - 1)); end
            if (k == 11) begin a1 = W'($urandom); b1 = W'($urandom); end
            if (k == 21) begin v0 = 1'b0; v1 = 1'b0; end
            #1;
            exp_r0 = 1'b0; exp_r1 = 1'b0;
            if (k == 0 || k == 10 || k == 20) begin
                exp_id = (v0 && v1) ? !m_last : v1;
                exp_r0 = !exp_id; exp_r1 = exp_id; m_last = exp_id;
                if (exp_id) exp_q.push_back({exp_id, (a1 == b1), ~(a1 ^ b1)});
                else        exp_q.push_back({exp_id, (a0 == b0), ~(a0 ^ b0)});
            end
            total++; if ({r0, r1} !== {exp_r0, exp_r1}) begin bad++;
                $display("FAIL arb_ready cycle %0d: got %b%b exp %b%b", k, r0, r1, exp_r0, exp_r1); end
            exp_rv = (k == 9 || k == 19 || k == 29);
            total++; if (rv !== exp_rv) begin bad++;
                $display("FAIL arb_res_valid cycle %0d: got %b exp %b", k, rv, exp_rv); end
            if (rv === 1'b1 && exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                got = {rid, req, rx};
                n_res++;
                total++; if (got !== exp) begin bad++;
                    $display("FAIL arb_result cycle %0d: got id/eq/x=%h exp %h", k, got, exp); end
            end
        end
        total++; if (n_res != 3 || exp_q.size() != 0) begin bad++;
            $display("FAIL arb_result_count: got %0d left %0d exp 3 left 0", n_res, exp_q.size()); end
    endtask

    task automatic test_reset_mid_op;
        logic [W-1:0] a, b;
        bit           saw_rv;
        tick; v0 = 1'b1; a0 = W'($urandom); b0 = W'($urandom);
        tick; v0 = 1'b0;
        tick; tick;
        tick; rst = 1'b1;
        tick; rst = 1'b0; #1;
        total++; if ({r0, r1, xa, xb, busy, rv, rid, req, rx} !== '0) begin bad++;
            $display("FAIL rstmid_outputs: busy=%b rv=%b id=%b eq=%b rx=%h exp all 0", busy, rv, rid, req, rx); end
        saw_rv = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick; #1;
            if (rv === 1'b1) saw_rv = 1'b1;
        end
        total++; if (saw_rv !== 1'b0) begin bad++;
            $display("FAIL rstmid_no_result: got res_valid=1 exp 0"); end
        // Abort a second operation and re-present immediately after reset
        tick; v0 = 1'b1; a0 = W'($urandom); b0 = W'($urandom);
        tick; v0 = 1'b0;
        tick; tick;
        tick; rst = 1'b1;
        tick; rst = 1'b0;
        a = W'($urandom); b = W'($urandom);
        run_pair(1'b1, a, b, 11);
        total++; if (t_r1[0] !== 1'b1) begin bad++;
            $display("FAIL rstmid_reaccept: got %b exp 1", t_r1[0]); end
        total++; if ({t_rv[9], t_rid[9], t_req[9], t_rx[9]} !== {1'b1, 1'b1, (a == b), ~(a ^ b)}) begin bad++;
            $display("FAIL rstmid_result: got rv=%b id=%b eq=%b rx=%h exp 1 1 %b %h",
                     t_rv[9], t_rid[9], t_req[9], t_rx[9], (a == b), ~(a ^ b)); end
    endtask

    task automatic test_random;
        logic [W-1:0] a, b;
        logic [10:0]  obs_xa, exp_xa;
        bit           id;
        for (int n = 0; n < 16; n++) begin
            id = 1'($urandom_range(0, 1));
            a  = W'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
            tick; run_pair(id, a, b, 11);
            for (int k = 0; k <= 10; k++) begin
                obs_xa[k] = t_xa[k];
                exp_xa[k] = (k >= 1 && k <= W) ? a[k-1] : 1'b0;
            end
            total++; if ({t_r0[0], t_r1[0]} !== {!id, id}) begin bad++;
                $display("FAIL rand_ready #%0d: got %b%b exp %b%b", n, t_r0[0], t_r1[0], !id, id); end
            total++; if (obs_xa !== exp_xa) begin bad++;
                $display("FAIL rand_xa_trace #%0d: got %b exp %b", n, obs_xa, exp_xa); end
            total++; if ({t_rv[8], t_rv[9], t_rid[9], t_req[9], t_rx[9]} !== {1'b0, 1'b1, id, (a == b), ~(a ^ b)}) begin bad++;
                $display("FAIL rand_result #%0d a=%h b=%h: got rv=%b%b id=%b eq=%b rx=%h exp 01 %b %b %h",
                         n, a, b, t_rv[8], t_rv[9], t_rid[9], t_req[9], t_rx[9], id, (a == b), ~(a ^ b)); end
        end
    endtask

    task automatic test_width1;
        logic sa, sb;
        for (int p = 0; p < 2; p++) begin
            sa = 1'b1; sb = (p == 1);
            tick; s_v0 = 1'b1; s_a0 = sa; s_b0 = sb; #1;
            total++; if (s_r0 !== 1'b1) begin bad++;
                $display("FAIL w1_ready pair %0d: got %b exp 1", p, s_r0); end
            tick; s_v0 = 1'b0; #1;
            total++; if ({s_xa, s_xb, s_busy, s_rv} !== {sa, sb, 1'b1, 1'b0}) begin bad++;
                $display("FAIL w1_shift pair %0d: got xa=%b xb=%b busy=%b rv=%b", p, s_xa, s_xb, s_busy, s_rv); end
            tick; #1;
            total++; if ({s_rv, s_rid, s_req, s_rx} !== {1'b1, 1'b0, (sa == sb), ~(sa ^ sb)}) begin bad++;
                $display("FAIL w1_result pair %0d: got rv=%b id=%b eq=%b rx=%b exp 1 0 %b %b",
                         p, s_rv, s_rid, s_req, s_rx, (sa == sb), ~(sa ^ sb)); end
            tick; #1;
            total++; if ({s_rv, s_busy} !== 2'b00) begin bad++;
                $display("FAIL w1_after pair %0d: got rv=%b busy=%b exp 0 0", p, s_rv, s_busy); end
        end
    endtask

    initial begin
        rst = 1'b1;
        v0 = 1'b0; v1 = 1'b0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        s_v0 = 1'b0; s_v1 = 1'b0; s_a0 = '0; s_b0 = '0; s_a1 = '0; s_b1 = '0;
        test_reset;
        test_match;
        test_full_mismatch;
        test_single_bit;
        test_arbitration;
        test_reset_mid_op;
        test_random;
        test_width1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
